// File: rtl/block_lock_64b66b.sv
// Purpose: 64b/66b Rx block lock FSM with gearbox slip control and 64-bit block reassembly.
// Latency: block_valid_o one cycle after the second half is sampled; block_lock_o one cycle after the 64th clean header.
// Backpressure: none, so the stream runs at line rate. Blocks only emerge while locked. Optional counters under BLOCK_LOCK_STATS_EN.
module block_lock_64b66b #(
  parameter int unsigned SH_CNT_MAX     = 64,
  parameter int unsigned SH_INVALID_MAX = 16,
  parameter int unsigned SLIP_WAIT_CYC  = 136
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  head_i,
  input  logic        head_valid_i,
  output logic        slip_o,
  output logic        block_lock_o,
  output logic [63:0] block_o,
  output logic [1:0]  block_head_o,
  output logic        block_valid_o
`ifdef BLOCK_LOCK_STATS_EN
  ,
  output logic [15:0] slip_cnt_o,
  output logic [15:0] lock_loss_cnt_o
`endif
);

  typedef enum logic [1:0] {
    TEST_SH   = 2'd0,
    SLIP      = 2'd1,
    SLIP_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  sh_cnt_q, sh_cnt_d;
  logic [4:0]  sh_inv_q, sh_inv_d;
  logic [7:0]  timer_q, timer_d;
  logic        lock_q, lock_d;
  logic        slip_q, slip_d;

  logic        half_vld_q, half_vld_d;
  logic [31:0] half_dat_q, half_dat_d;
  logic [1:0]  half_head_q, half_head_d;
  logic [63:0] block_q, block_d;
  logic [1:0]  block_head_q, block_head_d;
  logic        block_vld_q, block_vld_d;

  logic        hdr_ok;
  logic [6:0]  cnt_inc;
  logic [4:0]  inv_inc;

  assign hdr_ok  = (head_i == 2'b01) || (head_i == 2'b10);
  assign cnt_inc = sh_cnt_q + 7'd1;
  assign inv_inc = sh_inv_q + {4'd0, ~hdr_ok};

  // Lock FSM: header window counting, slip request and post-slip settle timer.
  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    sh_inv_d = sh_inv_q;
    timer_d  = timer_q;
    lock_d   = lock_q;
    case (state_q)
      TEST_SH: begin
        if (head_valid_i) begin
          sh_cnt_d = cnt_inc;
          sh_inv_d = inv_inc;
          // Invalid-limit is checked first so it wins over a coincident window end.
          if ((!lock_q && !hdr_ok) || (lock_q && (inv_inc == 5'(SH_INVALID_MAX)))) begin
            state_d = SLIP;
            lock_d  = 1'b0;
          end else if (cnt_inc == 7'(SH_CNT_MAX)) begin
            if (inv_inc == 5'd0) lock_d = 1'b1;
            sh_cnt_d = 7'd0;
            sh_inv_d = 5'd0;
          end
        end
      end
      SLIP: begin
        lock_d   = 1'b0;
        sh_cnt_d = 7'd0;
        sh_inv_d = 5'd0;
        timer_d  = 8'(SLIP_WAIT_CYC - 1);
        state_d  = SLIP_WAIT;
      end
      SLIP_WAIT: begin
        if (timer_q == 8'd0) state_d = TEST_SH;
        else                 timer_d = timer_q - 8'd1;
      end
      default: state_d = TEST_SH;
    endcase
    // Registered slip: high exactly for the single SLIP cycle.
    slip_d = (state_d == SLIP);
  end

  // Word-pair assembly; anything pending is thrown away while slipping.
  always_comb begin
    half_vld_d   = half_vld_q;
    half_dat_d   = half_dat_q;
    half_head_d  = half_head_q;
    block_d      = block_q;
    block_head_d = block_head_q;
    block_vld_d  = 1'b0;
    if (state_q != TEST_SH) begin
      half_vld_d = 1'b0;
    end else if (head_valid_i) begin
      half_vld_d  = 1'b1;
      half_dat_d  = data_i;
      half_head_d = head_i;
    end else if (half_vld_q) begin
      half_vld_d = 1'b0;
      if (lock_q) begin
        block_d      = {half_dat_q, data_i};
        block_head_d = half_head_q;
        block_vld_d  = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= TEST_SH;
      sh_cnt_q     <= 7'd0;
      sh_inv_q     <= 5'd0;
      timer_q      <= 8'd0;
      lock_q       <= 1'b0;
      slip_q       <= 1'b0;
      half_vld_q   <= 1'b0;
      half_dat_q   <= 32'd0;
      half_head_q  <= 2'd0;
      block_q      <= 64'd0;
      block_head_q <= 2'd0;
      block_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      sh_inv_q     <= sh_inv_d;
      timer_q      <= timer_d;
      lock_q       <= lock_d;
      slip_q       <= slip_d;
      half_vld_q   <= half_vld_d;
      half_dat_q   <= half_dat_d;
      half_head_q  <= half_head_d;
      block_q      <= block_d;
      block_head_q <= block_head_d;
      block_vld_q  <= block_vld_d;
    end
  end

  assign slip_o        = slip_q;
  assign block_lock_o  = lock_q;
  assign block_o       = block_q;
  assign block_head_o  = block_head_q;
  assign block_valid_o = block_vld_q;

`ifdef BLOCK_LOCK_STATS_EN
  logic [15:0] slip_cnt_q, slip_cnt_d;
  logic [15:0] loss_cnt_q, loss_cnt_d;

  // Saturating event counters: one count per SLIP cycle, one per lock drop.
  always_comb begin
    slip_cnt_d = slip_cnt_q;
    loss_cnt_d = loss_cnt_q;
    if ((state_q == SLIP) && (slip_cnt_q != 16'hFFFF)) slip_cnt_d = slip_cnt_q + 16'd1;
    if (lock_q && !lock_d && (loss_cnt_q != 16'hFFFF)) loss_cnt_d = loss_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slip_cnt_q <= 16'd0;
      loss_cnt_q <= 16'd0;
    end else begin
      slip_cnt_q <= slip_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign slip_cnt_o      = slip_cnt_q;
  assign lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_block_lock_64b66b.sv
// Purpose: directed self-checking bench for block_lock_64b66b.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: not applicable; the stream is driven every cycle.
module tb_block_lock_64b66b;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] data_i = 32'd0;
  logic [1:0]  head_i = 2'd0;
  logic        head_valid_i = 1'b0;
  logic        slip_o;
  logic        block_lock_o;
  logic [63:0] block_o;
  logic [1:0]  block_head_o;
  logic        block_valid_o;
`ifdef BLOCK_LOCK_STATS_EN
  logic [15:0] slip_cnt_o;
  logic [15:0] lock_loss_cnt_o;
`endif

  block_lock_64b66b dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_i        (data_i),
    .head_i        (head_i),
    .head_valid_i  (head_valid_i),
    .slip_o        (slip_o),
    .block_lock_o  (block_lock_o),
    .block_o       (block_o),
    .block_head_o  (block_head_o),
    .block_valid_o (block_valid_o)
`ifdef BLOCK_LOCK_STATS_EN
    ,
    .slip_cnt_o      (slip_cnt_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int slip_hits = 0;
  int valid_hits = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample just after the rising edge.
  task automatic step(input logic hv, input logic [1:0] h, input logic [31:0] d);
    @(negedge clk_i);
    head_valid_i = hv;
    head_i       = h;
    data_i       = d;
    @(posedge clk_i);
    #1;
    if (slip_o === 1'b1) slip_hits++;
    if (block_valid_o === 1'b1) valid_hits++;
  endtask

  task automatic pair(input logic [1:0] h, input logic [31:0] a, input logic [31:0] b);
    step(1'b1, h, a);
    step(1'b0, 2'b00, b);
  endtask

  initial begin
    int gap;
    bit got;

    // Reset state.
    rst_i = 1'b1;
    step(1'b0, 2'b00, 32'd0);
    step(1'b0, 2'b00, 32'd0);
    chk("rst_slip", slip_o, 0);
    chk("rst_lock", block_lock_o, 0);
    chk("rst_block", block_o, 0);
    chk("rst_head", block_head_o, 0);
    chk("rst_valid", block_valid_o, 0);
    rst_i = 1'b0;

    // Aligned stream: lock after the 64th header, no slip, block after lock.
    slip_hits = 0; valid_hits = 0;
    for (int i = 0; i < 63; i++) pair(2'b01, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i));
    chk("t1_lock_63", block_lock_o, 0);
    chk("t1_valid_unlocked", valid_hits, 0);
    step(1'b1, 2'b01, 32'h1000_003F);
    chk("t1_lock_64", block_lock_o, 1);
    step(1'b0, 2'b00, 32'h2000_003F);
    chk("t1_valid", block_valid_o, 1);
    chk("t1_block", block_o, 64'h1000_003F_2000_003F);
    chk("t1_head", block_head_o, 2'b01);
    chk("t1_no_slip", slip_hits, 0);

    // Known block contents with header 10, then an idle word.
    step(1'b1, 2'b10, 32'hDEADBEEF);
    chk("t4_valid_first", block_valid_o, 0);
    step(1'b0, 2'b00, 32'h01234567);
    chk("t4_valid", block_valid_o, 1);
    chk("t4_block", block_o, 64'hDEADBEEF_01234567);
    chk("t4_head", block_head_o, 2'b10);
    step(1'b0, 2'b00, 32'hCAFE0000);
    chk("t4_valid_pulse", block_valid_o, 0);
    chk("t4_block_hold", block_o, 64'hDEADBEEF_01234567);

    // Second header on the expected second-half cycle replaces the pending half.
    step(1'b1, 2'b01, 32'hAAAA_AAAA);
    step(1'b1, 2'b10, 32'hBBBB_BBBB);
    chk("drop_valid", block_valid_o, 0);
    step(1'b0, 2'b00, 32'hCCCC_CCCC);
    chk("drop_block", block_o, 64'hBBBB_BBBB_CCCC_CCCC);
    chk("drop_head", block_head_o, 2'b10);

    // 15 invalid headers in a window keep lock; window total so far is 3.
    slip_hits = 0;
    for (int i = 0; i < 15; i++) pair(2'b11, 32'h3000_0000 + 32'(i), 32'h4000_0000);
    chk("t3_lock_15", block_lock_o, 1);
    for (int i = 0; i < 46; i++) pair(2'b01, 32'h5000_0000 + 32'(i), 32'h6000_0000);
    chk("t3_lock_window_end", block_lock_o, 1);
    chk("t3_no_slip_15", slip_hits, 0);
    // Fresh window: 16 invalid headers drop lock on the 16th.
    for (int i = 0; i < 15; i++) pair(2'b11, 32'h7000_0000 + 32'(i), 32'h8000_0000);
    chk("t3_lock_15b", block_lock_o, 1);
    chk("t3_no_slip_15b", slip_hits, 0);
    step(1'b1, 2'b00, 32'h7000_00FF);
    chk("t3_slip_16", slip_o, 1);
    chk("t3_lock_16", block_lock_o, 0);

    // Misaligned stream: every word carries a bad header; slips spaced by the settle time.
    valid_hits = 0;
    gap = 0; got = 1'b0;
    for (int i = 1; i <= 300 && !got; i++) begin
      step(1'b1, 2'b11, 32'h9000_0000 + 32'(i));
      if (slip_o === 1'b1) begin gap = i; got = 1'b1; end
    end
    chk("t2_gap1", gap, 138);
    gap = 0; got = 1'b0;
    for (int i = 1; i <= 300 && !got; i++) begin
      step(1'b1, 2'b11, 32'h9100_0000 + 32'(i));
      if (slip_o === 1'b1) begin gap = i; got = 1'b1; end
    end
    chk("t2_gap2", gap, 138);
    chk("t2_no_valid", valid_hits, 0);

    // Alignment found: bad headers during the settle window are ignored.
    slip_hits = 0;
    for (int i = 0; i < 137; i++) step(1'b1, 2'b11, 32'hA000_0000 + 32'(i));
    chk("t2_wait_ignored", slip_hits, 0);
    for (int i = 0; i < 63; i++) pair(2'b01, 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i));
    chk("t2_lock_63", block_lock_o, 0);
    step(1'b1, 2'b01, 32'hB000_003F);
    chk("t2_lock_64", block_lock_o, 1);
    step(1'b0, 2'b00, 32'hC000_003F);
    chk("t2_block", block_o, 64'hB000_003F_C000_003F);
    chk("t2_no_slip", slip_hits, 0);
`ifdef BLOCK_LOCK_STATS_EN
    chk("t6_slip_cnt", slip_cnt_o, 16'd3);
    chk("t6_loss_cnt", lock_loss_cnt_o, 16'd1);
`endif

    // Reset mid-window and mid-block.
    step(1'b1, 2'b01, 32'hD000_0001);
    rst_i = 1'b1;
    step(1'b0, 2'b00, 32'hD000_0002);
    chk("t5_lock", block_lock_o, 0);
    chk("t5_valid", block_valid_o, 0);
    chk("t5_block", block_o, 0);
    chk("t5_head", block_head_o, 0);
    chk("t5_slip", slip_o, 0);
`ifdef BLOCK_LOCK_STATS_EN
    chk("t5_slip_cnt", slip_cnt_o, 16'd0);
    chk("t5_loss_cnt", lock_loss_cnt_o, 16'd0);
`endif
    rst_i = 1'b0;
    step(1'b0, 2'b00, 32'hD000_0003);
    chk("t5_half_dropped", block_valid_o, 0);
    for (int i = 0; i < 63; i++) pair(2'b10, 32'hE000_0000 + 32'(i), 32'hF000_0000 + 32'(i));
    chk("t5_lock_63", block_lock_o, 0);
    step(1'b1, 2'b10, 32'hE000_003F);
    chk("t5_lock_64", block_lock_o, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
